// File: rtl/de2_sopc_cpu_oci_pkg.sv
// Shared types and default widths for the OCI trace frame FIFO.
//   oci_tf_state_t : drain sequencer states (RUN, DRAIN, DONE)
//   oci_frame_t    : one stored frame {packed slot data, clamped slot count}
//   clamp_count    : limits a raw dct_count to SLOTS
package de2_sopc_cpu_oci_pkg;

   localparam int unsigned SLOT_W  = 10;
   localparam int unsigned SLOTS   = 3;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned FRAME_W = SLOTS * SLOT_W;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} oci_tf_state_t;

   typedef struct packed {
      logic [FRAME_W-1:0] data;
      logic [CNT_W-1:0]   count;
   } oci_frame_t;

   function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
      return (c > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : c;
   endfunction

endpackage

// File: rtl/de2_sopc_cpu_oci_frame_fifo.sv
// Single-clock synchronous FIFO with registered storage.
// Ports:
//   clk, reset       clock, synchronous active-high reset (pointers/level only)
//   push, wdata      write request and data; ignored when full
//   pop, rdata       read request; rdata shows the head entry combinationally
//   full, empty      status
//   level            number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module de2_sopc_cpu_oci_frame_fifo #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q;
   logic             do_push, do_pop;

   assign full    = (level_q == (AW+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      level_q <= level_q + 1'b1;
         else if (do_pop && !do_push) level_q <= level_q - 1'b1;
      end
   end

   // Storage needs no reset: contents are only visible through valid entries.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/de2_sopc_cpu_oci_trace_fifo.sv
// OCI debug-trace frame buffer: queues packed DCT frames, unpacks them into single slots on a
// valid/ready stream and sequences the end-of-test drain.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   dct_valid/buffer/count   incoming packed frame and its slot count
//   test_ending              drain request (level or pulse)
//   out_valid/ready          slot stream handshake
//   out_slot, out_last       current slot, final slot of its frame
//   fill_level               frames in FIFO (frame in unpacker not included)
//   drop_count               frames lost on full, saturating
//   count_err                sticky: a dct_count larger than SLOTS was seen
//   test_has_ended           drain complete, held until reset
// Build option: define OCI_TRACE_DROP_CNT_EN to enable drop_count (otherwise tied to 0).
module de2_sopc_cpu_oci_trace_fifo
   import de2_sopc_cpu_oci_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DROP_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   dct_valid,
   input  logic [FRAME_W-1:0]     dct_buffer,
   input  logic [CNT_W-1:0]       dct_count,
   input  logic                   test_ending,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SLOT_W-1:0]      out_slot,
   output logic                   out_last,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic [DROP_W-1:0]      drop_count,
   output logic                   count_err,
   output logic                   test_has_ended
);

   oci_tf_state_t state_q, state_d;

   logic                       push_req, push, pop, full, empty;
   logic                       slot_hs, last_hs;
   logic [$bits(oci_frame_t)-1:0] fifo_rdata;
   oci_frame_t                 push_frame, frame_q;
   logic [CNT_W-1:0]           idx_q;
   logic                       busy_q, count_err_q;

   // Frames are only accepted while running; zero-slot frames carry nothing.
   assign push_req   = dct_valid && (state_q == RUN) && (dct_count != '0);
   assign push       = push_req && !full;
   assign push_frame = '{data: dct_buffer, count: clamp_count(dct_count)};

   de2_sopc_cpu_oci_frame_fifo #(
      .WIDTH ($bits(oci_frame_t)),
      .DEPTH (DEPTH)
   ) u_frame_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_frame),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .level (fill_level)
   );

   // Unpacker
   assign out_valid = busy_q;
   assign out_last  = busy_q && (idx_q == frame_q.count - 1'b1);
   assign slot_hs   = busy_q && out_ready;
   assign last_hs   = slot_hs && out_last;
   // Load when idle, or on the final slot handshake so frames stream back-to-back.
   assign pop       = !empty && (!busy_q || last_hs);

   always_comb begin
      out_slot = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (idx_q == CNT_W'(i)) out_slot = frame_q.data[i*SLOT_W +: SLOT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_q <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else if (pop) begin
         frame_q <= oci_frame_t'(fifo_rdata);
         idx_q   <= '0;
         busy_q  <= 1'b1;
      end else if (last_hs) begin
         busy_q  <= 1'b0;
      end else if (slot_hs) begin
         idx_q   <= idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_err_q <= 1'b0;
      end else if (dct_valid && (state_q == RUN) && (dct_count > CNT_W'(SLOTS))) begin
         count_err_q <= 1'b1;
      end
   end
   assign count_err = count_err_q;

`ifdef OCI_TRACE_DROP_CNT_EN
   logic [DROP_W-1:0] drop_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
      end else if (push_req && full && (drop_q != '1)) begin
         drop_q <= drop_q + 1'b1;
      end
   end
   assign drop_count = drop_q;
`else
   assign drop_count = '0;
`endif

   // Drain sequencer
   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:   if (test_ending) state_d = DRAIN;
         // Finishing on the last handshake edge raises test_has_ended right after it.
         DRAIN: if (empty && (!busy_q || last_hs)) state_d = DONE;
         DONE:  state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   assign test_has_ended = (state_q == DONE);

endmodule

// File: tb/tb_de2_sopc_cpu_oci_trace_fifo.sv
module tb_de2_sopc_cpu_oci_trace_fifo;

   localparam int unsigned SLOT_W = 10;
   localparam int unsigned SLOTS  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned DROP_W = 16;
`ifdef OCI_TRACE_DROP_CNT_EN
   localparam int unsigned EXP_DROP = 1;
`else
   localparam int unsigned EXP_DROP = 0;
`endif

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     dct_valid = 1'b0;
   logic [SLOTS*SLOT_W-1:0]  dct_buffer = '0;
   logic [CNT_W-1:0]         dct_count = '0;
   logic                     test_ending = 1'b0;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic [SLOT_W-1:0]        out_slot;
   logic                     out_last;
   logic [$clog2(DEPTH):0]   fill_level;
   logic [DROP_W-1:0]        drop_count;
   logic                     count_err;
   logic                     test_has_ended;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   de2_sopc_cpu_oci_trace_fifo #(
      .DEPTH  (DEPTH),
      .DROP_W (DROP_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .dct_valid      (dct_valid),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_ending    (test_ending),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_slot       (out_slot),
      .out_last       (out_last),
      .fill_level     (fill_level),
      .drop_count     (drop_count),
      .count_err      (count_err),
      .test_has_ended (test_has_ended)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SLOTS*SLOT_W-1:0] frame3(input logic [9:0] s2, input logic [9:0] s1,
                                                      input logic [9:0] s0);
      return {s2, s1, s0};
   endfunction

   logic [SLOT_W-1:0] got [$];
   logic [SLOT_W-1:0] exp_q [$];
   logic [SLOT_W-1:0] prev_slot;
   logic              prev_stall;

   initial begin
      // Reset
      tick(); tick();
      reset = 1'b0;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_slot", 32'(out_slot), 0);
      check("rst_fill", 32'(fill_level), 0);
      check("rst_drop", 32'(drop_count), 0);
      check("rst_count_err", 32'(count_err), 0);
      check("rst_ended", 32'(test_has_ended), 0);

      // One 3-slot frame with sink always ready
      out_ready  = 1'b1;
      dct_valid  = 1'b1;
      dct_buffer = frame3(10'h3FF, 10'h155, 10'h001);
      dct_count  = 4'd3;
      tick();
      dct_valid = 1'b0;
      check("f1_fill_after_accept", 32'(fill_level), 1);
      check("f1_no_valid_yet", 32'(out_valid), 0);
      tick();
      check("f1_s0_valid", 32'(out_valid), 1);
      check("f1_s0", 32'(out_slot), 32'h001);
      check("f1_s0_last", 32'(out_last), 0);
      check("f1_fill_after_load", 32'(fill_level), 0);
      tick();
      check("f1_s1", 32'(out_slot), 32'h155);
      check("f1_s1_last", 32'(out_last), 0);
      tick();
      check("f1_s2", 32'(out_slot), 32'h3FF);
      check("f1_s2_last", 32'(out_last), 1);
      tick();
      check("f1_idle", 32'(out_valid), 0);

      // Fill to full with sink stalled, then overflow by one
      out_ready = 1'b0;
      dct_count = 4'd1;
      dct_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         dct_buffer = frame3(10'h0, 10'h0, 10'(i));
         tick();
      end
      check("fill_7", 32'(fill_level), 7);
      dct_buffer = frame3(10'h0, 10'h0, 10'd8);
      tick();
      check("fill_8", 32'(fill_level), 8);
      check("drop_before_overflow", 32'(drop_count), 0);
      dct_buffer = frame3(10'h0, 10'h0, 10'd9);
      tick();
      dct_valid = 1'b0;
      check("fill_8_after_drop", 32'(fill_level), 8);
      check("drop_count", 32'(drop_count), EXP_DROP);
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("drain_full_valid_%0d", i), 32'(out_valid), 1);
         check($sformatf("drain_full_slot_%0d", i), 32'(out_slot), i);
         check($sformatf("drain_full_last_%0d", i), 32'(out_last), 1);
         tick();
      end
      check("drain_full_empty", 32'(out_valid), 0);
      check("drain_full_fill0", 32'(fill_level), 0);

      // Over-count frame is clamped; zero-count frame is ignored
      dct_valid  = 1'b1;
      dct_buffer = frame3(10'h003, 10'h002, 10'h001);
      dct_count  = 4'd5;
      tick();
      dct_valid = 1'b0;
      check("cerr_set", 32'(count_err), 1);
      tick();
      check("clamp_s0", 32'(out_slot), 32'h001);
      tick();
      check("clamp_s1", 32'(out_slot), 32'h002);
      tick();
      check("clamp_s2", 32'(out_slot), 32'h003);
      check("clamp_s2_last", 32'(out_last), 1);
      tick();
      check("clamp_done", 32'(out_valid), 0);
      check("cerr_sticky", 32'(count_err), 1);
      dct_valid = 1'b1;
      dct_count = 4'd0;
      tick();
      dct_valid = 1'b0;
      check("zero_fill", 32'(fill_level), 0);
      tick();
      check("zero_no_valid", 32'(out_valid), 0);

      // Toggling ready across two frames
      dct_valid  = 1'b1;
      dct_buffer = frame3(10'h103, 10'h102, 10'h101);
      dct_count  = 4'd3;
      out_ready  = 1'b0;
      tick();
      dct_buffer = frame3(10'h000, 10'h202, 10'h201);
      dct_count  = 4'd2;
      tick();
      dct_valid  = 1'b0;
      prev_stall = 1'b0;
      prev_slot  = '0;
      for (int c = 0; c < 30; c++) begin
         out_ready = c[0];
         if (prev_stall) check("stall_stable", 32'(out_slot), 32'(prev_slot));
         if (out_valid && out_ready) got.push_back(out_slot);
         prev_stall = out_valid && !out_ready;
         prev_slot  = out_slot;
         tick();
      end
      exp_q = '{10'h101, 10'h102, 10'h103, 10'h201, 10'h202};
      check("toggle_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("toggle_slot_%0d", i), 32'(got[i]), 32'(exp_q[i]));

      // Drain sequencing
      out_ready = 1'b0;
      dct_count = 4'd1;
      dct_valid = 1'b1;
      dct_buffer = frame3(10'h0, 10'h0, 10'h011); tick();
      dct_buffer = frame3(10'h0, 10'h0, 10'h022); tick();
      dct_buffer = frame3(10'h0, 10'h0, 10'h033); tick();
      dct_valid   = 1'b0;
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      dct_valid   = 1'b1;
      dct_buffer = frame3(10'h0, 10'h0, 10'h044); tick();
      dct_buffer = frame3(10'h0, 10'h0, 10'h055); tick();
      dct_valid = 1'b0;
      check("drain_fill_ignored", 32'(fill_level), 2);
      check("drain_no_drop", 32'(drop_count), EXP_DROP);
      check("drain_not_ended", 32'(test_has_ended), 0);
      out_ready = 1'b1;
      check("drain_s0", 32'(out_slot), 32'h011);
      tick();
      check("drain_s1", 32'(out_slot), 32'h022);
      tick();
      check("drain_s2", 32'(out_slot), 32'h033);
      check("drain_s2_valid", 32'(out_valid), 1);
      check("drain_ended_early", 32'(test_has_ended), 0);
      tick();
      check("drain_ended", 32'(test_has_ended), 1);
      check("drain_idle", 32'(out_valid), 0);
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      check("done_held", 32'(test_has_ended), 1);

      // Reset in the middle of a frame while draining
      reset = 1'b1;
      tick();
      reset = 1'b0;
      out_ready  = 1'b0;
      dct_valid  = 1'b1;
      dct_buffer = frame3(10'h0C3, 10'h0B2, 10'h0A1);
      dct_count  = 4'd3;
      tick();
      dct_valid   = 1'b0;
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      check("pre_rst_busy", 32'(out_valid), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_slot", 32'(out_slot), 0);
      check("mid_rst_fill", 32'(fill_level), 0);
      check("mid_rst_cerr", 32'(count_err), 0);
      check("mid_rst_ended", 32'(test_has_ended), 0);
      check("mid_rst_drop", 32'(drop_count), 0);
      out_ready  = 1'b1;
      dct_valid  = 1'b1;
      dct_buffer = frame3(10'h0, 10'h0, 10'h0AA);
      dct_count  = 4'd1;
      tick();
      dct_valid = 1'b0;
      tick();
      check("post_rst_valid", 32'(out_valid), 1);
      check("post_rst_slot", 32'(out_slot), 32'h0AA);
      check("post_rst_last", 32'(out_last), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
